// File: rtl/count_readout_ser_if.sv
// Valid/ready handshake carrying {address, count} pairs into the readout stage.
interface count_readout_ser_if #(
    parameter int unsigned ADDR_BITS = 6,
    parameter int unsigned DATA_BITS = 12
);
    logic                 in_valid;
    logic                 in_ready;
    logic [ADDR_BITS-1:0] in_addr;
    logic [DATA_BITS-1:0] in_data;

    modport master (
        output in_valid,
        output in_addr,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_addr,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/count_readout_ser.sv
// Serial readout stage: buffers {addr, count} pairs in a FIFO and emits each
// as a framed, even-parity serial stream (start bit, addr, data, parity).
module count_readout_ser #(
    parameter int unsigned ADDR_BITS  = 6,
    parameter int unsigned DATA_BITS  = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    count_readout_ser_if.slave in_if,
    output logic               sdo,
    output logic               sdo_frame,
    output logic               busy
);
    localparam int unsigned PAIR_W    = ADDR_BITS + DATA_BITS;
    localparam int unsigned FRAME_LEN = PAIR_W + 2;
    localparam int unsigned SHR_W     = FRAME_LEN - 1;
    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned DIV_W     = $clog2(CLK_DIV);
    localparam int unsigned BIT_W     = $clog2(FRAME_LEN);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [PAIR_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PAIR_W-1:0] head_c;
    logic              push_c;
    logic              pop_c;

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [SHR_W-1:0]  shr_q, shr_d;
    logic              sdo_q, sdo_d;
    logic              frame_q, frame_d;
    logic              busy_q, busy_d;

    // Ready only from the registered occupancy; forced low while in reset.
    assign in_if.in_ready = (cnt_q < CNT_W'(FIFO_DEPTH)) && rst_n;
    assign push_c         = in_if.in_valid && in_if.in_ready;
    assign head_c         = mem_q[rd_ptr_q];

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= {in_if.in_addr, in_if.in_data};
        end
    end

    // FIFO pointer and occupancy update; pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Frame sequencer: load on pop, hold each bit CLK_DIV cycles, then a gap.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shr_d   = shr_q;
        sdo_d   = sdo_q;
        frame_d = frame_q;
        pop_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sdo_d   = 1'b0;
                frame_d = 1'b0;
                if (cnt_q != '0) begin
                    pop_c   = 1'b1;
                    shr_d   = {head_c, ^head_c};
                    sdo_d   = 1'b1;
                    frame_d = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (bit_q == BIT_W'(FRAME_LEN - 1)) begin
                        bit_d   = '0;
                        sdo_d   = 1'b0;
                        frame_d = 1'b0;
                        state_d = ST_GAP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        sdo_d = shr_q[SHR_W-1];
                        shr_d = {shr_q[SHR_W-2:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_GAP: begin
                sdo_d   = 1'b0;
                frame_d = 1'b0;
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                sdo_d   = 1'b0;
                frame_d = 1'b0;
                div_d   = '0;
                bit_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (cnt_d != '0) || (state_d != ST_IDLE);
    end

    // State, counters and registered outputs; reset discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shr_q    <= '0;
            sdo_q    <= 1'b0;
            frame_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shr_q    <= shr_d;
            sdo_q    <= sdo_d;
            frame_q  <= frame_d;
            busy_q   <= busy_d;
        end
    end

    assign sdo       = sdo_q;
    assign sdo_frame = frame_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_count_readout_ser.sv
// Bench for count_readout_ser: default instance (CLK_DIV=4, depth 4) and a
// CLK_DIV=2 / depth 2 instance, checked against a frame-level reference model.
module tb_count_readout_ser;
    localparam int unsigned AB    = 6;
    localparam int unsigned DB    = 12;
    localparam int unsigned DIV_A = 4;
    localparam int unsigned DIV_B = 2;
    localparam int unsigned LEN   = AB + DB + 2;
    localparam int          TMO   = 3000;

    typedef struct {
        logic [31:0] bits;
        int          ncyc;
        bit          stable;
        int          start;
    } frm_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    count_readout_ser_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) ifa ();
    count_readout_ser_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) ifb ();
    logic sdo_a, frame_a, busy_a;
    logic sdo_b, frame_b, busy_b;

    count_readout_ser #(.ADDR_BITS(AB), .DATA_BITS(DB), .FIFO_DEPTH(4), .CLK_DIV(DIV_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_if(ifa), .sdo(sdo_a), .sdo_frame(frame_a), .busy(busy_a)
    );
    count_readout_ser #(.ADDR_BITS(AB), .DATA_BITS(DB), .FIFO_DEPTH(2), .CLK_DIV(DIV_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_if(ifb), .sdo(sdo_b), .sdo_frame(frame_b), .busy(busy_b)
    );

    // Frame capture monitors
    frm_t        cap_a[$], cap_b[$];
    frm_t        cur_a, cur_b;
    bit          in_a = 0, in_b = 0;
    int          stray_a = 0, stray_b = 0;
    logic [31:0] exp_a[$], exp_b[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            in_a = 0;
        end else if (frame_a) begin
            if (!in_a) begin
                in_a = 1; cur_a.bits = '0; cur_a.ncyc = 0; cur_a.stable = 1; cur_a.start = cyc;
            end
            if (cur_a.ncyc % DIV_A == 0) cur_a.bits = {cur_a.bits[30:0], sdo_a};
            else if (sdo_a !== cur_a.bits[0]) cur_a.stable = 0;
            cur_a.ncyc++;
        end else begin
            if (sdo_a !== 1'b0) stray_a++;
            if (in_a) begin in_a = 0; cap_a.push_back(cur_a); end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            in_b = 0;
        end else if (frame_b) begin
            if (!in_b) begin
                in_b = 1; cur_b.bits = '0; cur_b.ncyc = 0; cur_b.stable = 1; cur_b.start = cyc;
            end
            if (cur_b.ncyc % DIV_B == 0) cur_b.bits = {cur_b.bits[30:0], sdo_b};
            else if (sdo_b !== cur_b.bits[0]) cur_b.stable = 0;
            cur_b.ncyc++;
        end else begin
            if (sdo_b !== 1'b0) stray_b++;
            if (in_b) begin in_b = 0; cap_b.push_back(cur_b); end
        end
    end

    // Reference frame: start bit, addr, data, even parity over addr+data.
    function automatic logic [31:0] ref_frame(input int addr, input int data);
        int ones = 0;
        for (int i = 0; i < AB; i++) ones += (addr >> i) & 1;
        for (int i = 0; i < DB; i++) ones += (data >> i) & 1;
        return 32'((1 << (AB + DB + 1)) + (addr << (DB + 1)) + (data << 1) + (ones % 2));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a pair (called just after a rising edge); returns the accepting edge.
    task automatic push_a(input int addr, input int data, output int acc);
        int w = 0;
        ifa.in_valid = 1'b1; ifa.in_addr = AB'(addr); ifa.in_data = DB'(data);
        while (ifa.in_ready !== 1'b1 && w < TMO) begin @(posedge clk); #1; w++; end
        if (w >= TMO) chk("push_a_timeout", 32'(ifa.in_ready), 32'd1);
        @(posedge clk); #1;
        acc = cyc;
    endtask

    task automatic push_b(input int addr, input int data, output int acc);
        int w = 0;
        ifb.in_valid = 1'b1; ifb.in_addr = AB'(addr); ifb.in_data = DB'(data);
        while (ifb.in_ready !== 1'b1 && w < TMO) begin @(posedge clk); #1; w++; end
        if (w >= TMO) chk("push_b_timeout", 32'(ifb.in_ready), 32'd1);
        @(posedge clk); #1;
        acc = cyc;
    endtask

    task automatic idle_a();
        ifa.in_valid = 1'b0; ifa.in_addr = AB'($urandom); ifa.in_data = DB'($urandom);
    endtask

    task automatic idle_b();
        ifb.in_valid = 1'b0; ifb.in_addr = AB'($urandom); ifb.in_data = DB'($urandom);
    endtask

    task automatic wait_idle_a();
        int w = 0;
        while (busy_a && w < TMO) begin @(posedge clk); #1; w++; end
        chk("idle_a", 32'(busy_a), 32'd0);
    endtask

    task automatic wait_idle_b();
        int w = 0;
        while (busy_b && w < 5 * TMO) begin @(posedge clk); #1; w++; end
        chk("idle_b", 32'(busy_b), 32'd0);
    endtask

    task automatic check_frames_a(input string tag);
        frm_t f;
        logic [31:0] e;
        chk({tag, "_nframes"}, 32'(cap_a.size()), 32'(exp_a.size()));
        while (exp_a.size() > 0 && cap_a.size() > 0) begin
            f = cap_a.pop_front();
            e = exp_a.pop_front();
            chk({tag, "_bits"}, f.bits, e);
            chk({tag, "_len"}, 32'(f.ncyc), 32'(LEN * DIV_A));
            chk({tag, "_stable"}, 32'(f.stable), 32'd1);
        end
        cap_a.delete();
        exp_a.delete();
    endtask

    task automatic check_frames_b(input string tag);
        frm_t f;
        logic [31:0] e;
        chk({tag, "_nframes"}, 32'(cap_b.size()), 32'(exp_b.size()));
        while (exp_b.size() > 0 && cap_b.size() > 0) begin
            f = cap_b.pop_front();
            e = exp_b.pop_front();
            chk({tag, "_bits"}, f.bits, e);
            chk({tag, "_len"}, 32'(f.ncyc), 32'(LEN * DIV_B));
            chk({tag, "_stable"}, 32'(f.stable), 32'd1);
        end
        cap_b.delete();
        exp_b.delete();
    endtask

    initial begin
        int acc;
        int acc_v[7];
        int s;
        int addr0, data0;
        logic [31:0] f0;

        idle_a();
        idle_b();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sdo", 32'(sdo_a), 32'd0);
        chk("rst_frame", 32'(frame_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ready_a", 32'(ifa.in_ready), 32'd0);
        chk("rst_ready_b", 32'(ifb.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready_a", 32'(ifa.in_ready), 32'd1);
        chk("post_rst_ready_b", 32'(ifb.in_ready), 32'd1);
        chk("post_rst_busy", 32'(busy_a), 32'd0);

        // Single frame: addr 2A, data ABC
        push_a(32'h2A, 32'hABC, acc);
        idle_a();
        exp_a.push_back(ref_frame(32'h2A, 32'hABC));
        wait_idle_a();
        chk("t1_busy_fall", 32'(cyc), 32'(acc + 1 + (LEN + 1) * DIV_A));
        if (cap_a.size() > 0) begin
            chk("t1_start", 32'(cap_a[0].start), 32'(acc + 1));
            chk("t1_literal", cap_a[0].bits, 32'h000D5578);
        end
        check_frames_a("t1");

        // Two back-to-back frames with opposite parity bits
        push_a(0, 32'h001, acc);
        push_a(63, 32'hFFF, s);
        idle_a();
        exp_a.push_back(ref_frame(0, 32'h001));
        exp_a.push_back(ref_frame(63, 32'hFFF));
        wait_idle_a();
        if (cap_a.size() > 1) begin
            chk("t2_start", 32'(cap_a[0].start), 32'(acc + 1));
            chk("t2_lit0", cap_a[0].bits, 32'h00080003);
            chk("t2_lit1", cap_a[1].bits, 32'h000FFFFE);
            chk("t2_spacing", 32'(cap_a[1].start - cap_a[0].start), 32'((LEN + 1) * DIV_A + 1));
        end
        check_frames_a("t2");

        // Seven pairs with valid held high: capacity and stall behaviour
        for (int i = 0; i < 7; i++) begin
            int d;
            d = int'($urandom_range(0, 4095));
            push_a(10 + i, d, acc_v[i]);
            exp_a.push_back(ref_frame(10 + i, d));
            if (i == 4) chk("t3_full_after5", 32'(ifa.in_ready), 32'd0);
            if (i == 5) chk("t3_full_after6", 32'(ifa.in_ready), 32'd0);
        end
        idle_a();
        for (int i = 1; i < 5; i++) chk("t3_b2b_accept", 32'(acc_v[i]), 32'(acc_v[0] + i));
        chk("t3_accept6", 32'(acc_v[5]), 32'(acc_v[0] + 1 + (LEN + 1) * DIV_A + 2));
        chk("t3_accept7", 32'(acc_v[6]), 32'(acc_v[0] + 1 + 2 * ((LEN + 1) * DIV_A + 1) + 1));
        wait_idle_a();
        check_frames_a("t3");

        // Reset during bit 9 with three pairs queued
        addr0 = 5;
        data0 = int'($urandom_range(0, 4095));
        f0 = ref_frame(addr0, data0);
        push_a(addr0, data0, acc);
        s = acc + 1;
        for (int i = 1; i < 4; i++) push_a(20 + i, int'($urandom_range(0, 4095)), acc_v[0]);
        idle_a();
        while (cyc < s + 9 * DIV_A + 1) begin @(posedge clk); #1; end
        chk("t4_in_frame", 32'(frame_a), 32'd1);
        chk("t4_bit9", 32'(sdo_a), 32'((f0 >> (LEN - 1 - 9)) & 1));
        rst_n = 1'b0;
        #1;
        chk("t4_rst_sdo", 32'(sdo_a), 32'd0);
        chk("t4_rst_frame", 32'(frame_a), 32'd0);
        chk("t4_rst_busy", 32'(busy_a), 32'd0);
        chk("t4_rst_ready", 32'(ifa.in_ready), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t4_ready_after", 32'(ifa.in_ready), 32'd1);
        repeat (150) begin @(posedge clk); #1; end
        chk("t4_no_resume", 32'(cap_a.size()), 32'd0);
        chk("t4_busy_low", 32'(busy_a), 32'd0);
        data0 = int'($urandom_range(0, 4095));
        push_a(42, data0, acc);
        idle_a();
        exp_a.push_back(ref_frame(42, data0));
        wait_idle_a();
        check_frames_a("t4");

        // CLK_DIV=2, depth-2 instance: 64 sequential addresses, random gaps
        for (int i = 0; i < 64; i++) begin
            int d;
            int gap;
            gap = int'($urandom_range(0, 3));
            if (gap > 0) begin
                idle_b();
                repeat (gap) begin @(posedge clk); #1; end
            end
            d = int'($urandom_range(0, 4095));
            push_b(i, d, acc);
            exp_b.push_back(ref_frame(i, d));
        end
        idle_b();
        wait_idle_b();
        check_frames_b("t5");

        chk("stray_a", 32'(stray_a), 32'd0);
        chk("stray_b", 32'(stray_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
